// File: rtl/csa_tree_pkg.sv
// csa_tree_pkg: stage-count arithmetic for the carry-save reduction tree.
// Every function is a constant function and is evaluated at elaboration time.
package csa_tree_pkg;

  // Upper bound on reduction stages; the count grows ~log1.5(n), so 32 is ample.
  localparam int MAX_STAGES = 32;

  function automatic int csa_next(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int csa_stages(input int n);
    int m;
    int s;
    m = n;
    s = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (m > 2) begin
        m = csa_next(m);
        s = s + 1;
      end
    end
    return s;
  endfunction

  function automatic int csa_width_at(input int n, input int k);
    int m;
    m = n;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (i < k) begin
        m = csa_next(m);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_layer.sv
// csa_layer_3to2: one combinational 3:2 compression layer.
// Output 2g is the sum of group g and 2g+1 its carry; leftover operands follow unchanged.
module csa_layer_3to2
  import csa_tree_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int WIDTH = 8
) (
  input  logic [N_IN-1:0][WIDTH-1:0]           ops_i,
  output logic [csa_next(N_IN)-1:0][WIDTH-1:0] ops_o
);

  localparam int NG = N_IN / 3;
  localparam int NL = N_IN % 3;

  for (genvar g = 0; g < NG; g++) begin : gen_grp
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    assign a = ops_i[3*g];
    assign b = ops_i[3*g+1];
    assign c = ops_i[3*g+2];
    assign ops_o[2*g]   = a ^ b ^ c;
    // Shifting at full width discards the majority bit that would land at WIDTH.
    assign ops_o[2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
  end

  for (genvar j = 0; j < NL; j++) begin : gen_pass
    assign ops_o[2*NG+j] = ops_i[3*NG+j];
  end

endmodule

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 3:2 carry-save tree plus registered final adder, valid/ready stream.
// Optional feature macro CSA_TREE_ACCUM_EN: accumulate tree sums per group closed by in_last_i.
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int NUM_OPS = 32,
  parameter int WIDTH   = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NUM_OPS-1:0][WIDTH-1:0] in_ops_i,
`ifdef CSA_TREE_ACCUM_EN
  input  logic                          in_last_i,
`endif
  input  logic                          out_ready_i,
  output logic                          out_valid_o,
  output logic [WIDTH-1:0]              out_sum_o
);

  localparam int S = csa_stages(NUM_OPS);

  if (NUM_OPS < 3) begin : gen_num_ops_check
    $error("csa_tree_pipe: NUM_OPS must be at least 3");
  end

  logic             adv;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] tree_sum;

  // One global enable: the whole pipe, bubbles included, moves only when the output can drain.
  assign adv        = !out_valid_q | out_ready_i;
  assign in_ready_o = adv;

  for (genvar k = 0; k < S; k++) begin : gen_stage
    localparam int NI = csa_width_at(NUM_OPS, k);
    localparam int NO = csa_next(NI);

    logic [NI-1:0][WIDTH-1:0] lay_in;
    logic [NO-1:0][WIDTH-1:0] lay_out, data_d, data_q;
    logic                     vld_src, vld_d, vld_q;
`ifdef CSA_TREE_ACCUM_EN
    logic                     last_src, last_d, last_q;
`endif

    if (k == 0) begin : g_head
      assign lay_in  = in_ops_i;
      assign vld_src = in_valid_i;
`ifdef CSA_TREE_ACCUM_EN
      assign last_src = in_last_i;
`endif
    end else begin : g_body
      assign lay_in  = gen_stage[k-1].data_q;
      assign vld_src = gen_stage[k-1].vld_q;
`ifdef CSA_TREE_ACCUM_EN
      assign last_src = gen_stage[k-1].last_q;
`endif
    end

    csa_layer_3to2 #(.N_IN(NI), .WIDTH(WIDTH)) u_layer (
      .ops_i(lay_in),
      .ops_o(lay_out)
    );

    always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
`ifdef CSA_TREE_ACCUM_EN
      last_d = last_q;
`endif
      if (adv) begin
        data_d = lay_out;
        vld_d  = vld_src;
`ifdef CSA_TREE_ACCUM_EN
        last_d = last_src;
`endif
      end else begin
        data_d = data_q;
      end
    end

    // Only control bits are reset; payload is qualified by vld_q.
    always_ff @(posedge clk_i) begin
      data_q <= data_d;
      if (!rst_ni) begin
        vld_q <= 1'b0;
`ifdef CSA_TREE_ACCUM_EN
        last_q <= 1'b0;
`endif
      end else begin
        vld_q <= vld_d;
`ifdef CSA_TREE_ACCUM_EN
        last_q <= last_d;
`endif
      end
    end
  end

  assign tree_sum = gen_stage[S-1].data_q[0] + gen_stage[S-1].data_q[1];

`ifdef CSA_TREE_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    acc_d       = acc_q;
    if (adv) begin
      out_valid_d = gen_stage[S-1].vld_q & gen_stage[S-1].last_q;
      if (gen_stage[S-1].vld_q) begin
        if (gen_stage[S-1].last_q) begin
          out_sum_d = acc_q + tree_sum;
          acc_d     = '0;
        end else begin
          acc_d     = acc_q + tree_sum;
        end
      end else begin
        acc_d = acc_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      acc_q       <= acc_d;
    end
  end
`else
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (adv) begin
      out_valid_d = gen_stage[S-1].vld_q;
      if (gen_stage[S-1].vld_q) begin
        out_sum_d = tree_sum;
      end else begin
        out_sum_d = out_sum_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed bench for csa_tree_pipe: a 32x64 instance and a 3x8 instance on a shared clock.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_csa_tree_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0][63:0] in_ops = '0;
  logic             in_last = 1'b1;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [63:0]      out_sum;

  logic             s_in_valid = 1'b0;
  logic             s_in_ready;
  logic [2:0][7:0]  s_in_ops = '0;
  logic             s_in_last = 1'b1;
  logic             s_out_ready = 1'b1;
  logic             s_out_valid;
  logic [7:0]       s_out_sum;

  int checks = 0;
  int failures = 0;

  csa_tree_pipe #(.NUM_OPS(32), .WIDTH(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ops_i(in_ops),
`ifdef CSA_TREE_ACCUM_EN
    .in_last_i(in_last),
`endif
    .out_ready_i(out_ready), .out_valid_o(out_valid), .out_sum_o(out_sum)
  );

  csa_tree_pipe #(.NUM_OPS(3), .WIDTH(8)) u_small (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_ops_i(s_in_ops),
`ifdef CSA_TREE_ACCUM_EN
    .in_last_i(s_in_last),
`endif
    .out_ready_i(s_out_ready), .out_valid_o(s_out_valid), .out_sum_o(s_out_sum)
  );

  // Drives one vector of identical operands, then records first-valid cycle, sum and beat count.
  task automatic send_uniform(input logic [63:0] val, output int first_hit,
                              output logic [63:0] sum_seen, output int beats);
    first_hit = -1;
    sum_seen = '0;
    beats = 0;
    for (int i = 0; i < 32; i++) in_ops[i] = val;
    in_last = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        beats++;
        if (first_hit < 0) begin
          first_hit = cyc;
          sum_seen = out_sum;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    s_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_sum !== 64'd0) begin
      failures++;
      $display("FAIL reset_out_sum got=%h want=0", out_sum);
    end
    checks++;
    if (s_out_valid !== 1'b0 || s_out_sum !== 8'd0) begin
      failures++;
      $display("FAIL reset_small got=%b/%h want=0/00", s_out_valid, s_out_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_ones();
    int hit;
    int beats;
    logic [63:0] s;
    send_uniform(64'd1, hit, s, beats);
    checks++;
    if (hit !== 9) begin
      failures++;
      $display("FAIL ones_latency got=%0d want=9", hit);
    end
    checks++;
    if (s !== 64'd32) begin
      failures++;
      $display("FAIL ones_sum got=%0d want=32", s);
    end
    checks++;
    if (beats !== 1) begin
      failures++;
      $display("FAIL ones_beats got=%0d want=1", beats);
    end
  endtask

  task automatic test_wrap();
    int hit;
    int beats;
    logic [63:0] s;
    send_uniform(64'hFFFF_FFFF_FFFF_FFFF, hit, s, beats);
    checks++;
    if (s !== 64'hFFFF_FFFF_FFFF_FFE0 || hit !== 9) begin
      failures++;
      $display("FAIL wrap_sum got=%h@%0d want=ffffffffffffffe0@9", s, hit);
    end
    checks++;
    if (beats !== 1) begin
      failures++;
      $display("FAIL wrap_beats got=%0d want=1", beats);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    logic [63:0] cur_exp;
    logic [63:0] held;
    logic [63:0] want;
    logic stall_prev;
    logic need_new;
    int sent;
    int got;
    cur_exp = '0;
    held = '0;
    stall_prev = 1'b0;
    need_new = 1'b1;
    sent = 0;
    got = 0;
    in_last = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== held) begin
          failures++;
          $display("FAIL stall_hold got=%b/%h want=1/%h", out_valid, out_sum, held);
        end
      end
      if (need_new) begin
        if (sent < 20) begin
          cur_exp = '0;
          for (int i = 0; i < 32; i++) begin
            in_ops[i] = {$urandom, $urandom};
            cur_exp = cur_exp + in_ops[i];
          end
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        need_new = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got=%h want=none", out_sum);
        end else begin
          want = exp_q.pop_front();
          if (out_sum !== want) begin
            failures++;
            $display("FAIL b2b_sum idx=%0d got=%h want=%h", got, out_sum, want);
          end
        end
        got++;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      held = out_sum;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(cur_exp);
        sent++;
        need_new = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 20 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=20 pending=%0d", got, exp_q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    int stray;
    stray = 0;
    out_ready = 1'b1;
    in_last = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 32; i++) in_ops[i] = 64'(v + i + 1);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL flush_valid got=%0d beats want=0", stray);
    end
    checks++;
    if (out_sum !== 64'd0) begin
      failures++;
      $display("FAIL flush_sum got=%h want=0", out_sum);
    end
  endtask

  task automatic test_small();
    s_in_ops[0] = 8'hFF;
    s_in_ops[1] = 8'h01;
    s_in_ops[2] = 8'h01;
    s_in_last = 1'b1;
    s_out_ready = 1'b1;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL small_early got=%b want=0", s_out_valid);
    end
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_sum !== 8'h01) begin
      failures++;
      $display("FAIL small_sum got=%b/%h want=1/01", s_out_valid, s_out_sum);
    end
  endtask

`ifdef CSA_TREE_ACCUM_EN
  // Beats summing 5, 7, 9 close one group; then a single-beat group summing 4.
  task automatic test_accum();
    int beats;
    logic [63:0] s;
    beats = 0;
    s = '0;
    out_ready = 1'b1;
    in_ops = '0; in_ops[0] = 64'd2; in_ops[1] = 64'd3; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_ops = '0; in_ops[7] = 64'd7; in_last = 1'b0;
    @(negedge clk);
    in_ops = '0; in_ops[5] = 64'd4; in_ops[31] = 64'd5; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        beats++;
        s = out_sum;
      end
    end
    checks++;
    if (beats !== 1 || s !== 64'd21) begin
      failures++;
      $display("FAIL accum_group got=%0d beats sum=%0d want=1 beat sum=21", beats, s);
    end
    beats = 0;
    in_ops = '0; in_ops[2] = 64'd4; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        beats++;
        s = out_sum;
      end
    end
    checks++;
    if (beats !== 1 || s !== 64'd4) begin
      failures++;
      $display("FAIL accum_single got=%0d beats sum=%0d want=1 beat sum=4", beats, s);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ones();
    test_wrap();
    test_back_to_back();
    test_reset_in_flight();
    test_small();
`ifdef CSA_TREE_ACCUM_EN
    test_accum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
